// File: rtl/paint_ctrl.sv
// paint_ctrl: debounced cursor stepping with auto-repeat and frame-buffer painting
module paint_ctrl #(
   parameter int          DEBOUNCE_CYCLES = 1_000_000,
   parameter int          HOLD_DELAY      = 25_000_000,
   parameter int          REPEAT_PERIOD   = 5_000_000,
   parameter logic [7:0]  X_INIT          = 8'h80,
   parameter logic [7:0]  Y_INIT          = 8'h80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        draw,
   input  logic [11:0] color,
   output logic [7:0]  x,
   output logic [7:0]  y,
   output logic        we,
   output logic [15:0] waddr,
   output logic [11:0] wdata
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   state_t      st;
   logic [4:0]  raw, s1, s2;
   logic [3:0]  dir, last;
   logic [24:0] tmr;
   logic        chg, hold_hit, rep_hit, step;
   logic [7:0]  nx, ny;
   assign raw = {draw, btn_up, btn_down, btn_left, btn_right};
   // two-flop synchronizers for all raw inputs, draw in bit 4
   always_ff @(posedge clk)
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_db
         logic [DW-1:0] cnt;
         logic          db;
         assign dir[i] = db;
         // accept a button change only after it has been stable for DEBOUNCE_CYCLES
         always_ff @(posedge clk)
            if (!rst) begin
               cnt <= '0;
               db  <= 1'b0;
            end else if (s2[i] == db)
               cnt <= '0;
            else if (cnt == DW'(DEBOUNCE_CYCLES)) begin
               cnt <= '0;
               db  <= ~db;
            end else
               cnt <= cnt + 1'b1;
      end
   endgenerate
   // step decision and next cursor position, modulo 256 on each axis
   always_comb begin
      chg      = dir != last;
      hold_hit = tmr == 25'(HOLD_DELAY - 1);
      rep_hit  = tmr == 25'(REPEAT_PERIOD - 1);
      step     = (dir != 4'd0) && (st == IDLE || chg || (st == HOLD ? hold_hit : rep_hit));
      nx       = x + {7'd0, dir[2]} - {7'd0, dir[3]};
      ny       = y + {7'd0, dir[0]} - {7'd0, dir[1]};
   end
   // step FSM: one step per press, then auto-repeat after the hold delay
   always_ff @(posedge clk)
      if (!rst) begin
         st   <= IDLE;
         tmr  <= '0;
         last <= '0;
         x    <= X_INIT;
         y    <= Y_INIT;
      end else begin
         last <= dir;
         tmr  <= (step || st == IDLE) ? '0 : tmr + 1'b1;
         x    <= step ? nx : x;
         y    <= step ? ny : y;
         st   <= dir == 4'd0 ? IDLE :
                 st == IDLE ? HOLD :
                 chg        ? HOLD :
                 st == HOLD ? (hold_hit ? REPEAT : HOLD) : REPEAT;
      end
   // write port follows the cursor one cycle behind, enabled by synchronized draw
   always_ff @(posedge clk)
      if (!rst) begin
         we    <= 1'b0;
         waddr <= {X_INIT, Y_INIT};
         wdata <= '0;
      end else begin
         we    <= s2[4];
         waddr <= {x, y};
         wdata <= color;
      end
endmodule

// File: tb/tb_paint_ctrl.sv
// tb_paint_ctrl: directed vector table plus timing sequences for paint_ctrl
module tb_paint_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic        draw = 1'b0;
   logic [11:0] color = '0;
   logic [7:0]  x, y;
   logic        we;
   logic [15:0] waddr;
   logic [11:0] wdata;
   int          checks = 0;
   int          errors = 0;
   paint_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_DELAY(20),
      .REPEAT_PERIOD(5),
      .X_INIT(8'h80),
      .Y_INIT(8'h80)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .draw(draw), .color(color),
      .x(x), .y(y), .we(we), .waddr(waddr), .wdata(wdata)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  btn;
      logic        drw;
      logic [11:0] col;
      int          n;
      logic [7:0]  ex;
      logic [7:0]  ey;
      logic        ewe;
      logic [15:0] ea;
      logic [11:0] ed;
   } vec_t;
   vec_t v[13];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic press(input logic [3:0] b);
      {btn_up, btn_down, btn_left, btn_right} = b;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic do_reset();
      press(4'b0000);
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask
   // steps seen k ticks after a button press: T at tick 8, T+20, then every 5
   function automatic int nsteps(input int k);
      return int'(k >= 8) + int'(k >= 28) + ((k >= 28) ? (k - 28) / 5 : 0);
   endfunction
   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0] e;
      v[0]  = '{4'b0000, 1'b0, 12'h000,  3, 8'h80, 8'h80, 1'b0, 16'h8080, 12'h000};
      v[1]  = '{4'b1001, 1'b0, 12'h000, 10, 8'h7F, 8'h81, 1'b0, 16'h7F81, 12'h000};
      v[2]  = '{4'b0000, 1'b0, 12'h000, 12, 8'h7F, 8'h81, 1'b0, 16'h7F81, 12'h000};
      v[3]  = '{4'b1100, 1'b0, 12'h000, 10, 8'h7F, 8'h81, 1'b0, 16'h7F81, 12'h000};
      v[4]  = '{4'b0000, 1'b0, 12'h000, 12, 8'h7F, 8'h81, 1'b0, 16'h7F81, 12'h000};
      v[5]  = '{4'b0110, 1'b0, 12'h000, 10, 8'h80, 8'h80, 1'b0, 16'h8080, 12'h000};
      v[6]  = '{4'b0000, 1'b0, 12'h000, 12, 8'h80, 8'h80, 1'b0, 16'h8080, 12'h000};
      v[7]  = '{4'b0000, 1'b1, 12'hF00,  3, 8'h80, 8'h80, 1'b1, 16'h8080, 12'hF00};
      v[8]  = '{4'b0001, 1'b1, 12'hF00,  8, 8'h80, 8'h81, 1'b1, 16'h8080, 12'hF00};
      v[9]  = '{4'b0001, 1'b1, 12'hF00,  1, 8'h80, 8'h81, 1'b1, 16'h8081, 12'hF00};
      v[10] = '{4'b0000, 1'b0, 12'hF00,  2, 8'h80, 8'h81, 1'b1, 16'h8081, 12'hF00};
      v[11] = '{4'b0000, 1'b0, 12'hF00,  1, 8'h80, 8'h81, 1'b0, 16'h8081, 12'hF00};
      v[12] = '{4'b0000, 1'b0, 12'hF00, 12, 8'h80, 8'h81, 1'b0, 16'h8081, 12'hF00};
      do_reset();
      chk("rst_x", x, 8'h80);
      chk("rst_y", y, 8'h80);
      chk("rst_we", we, 1'b0);
      chk("rst_waddr", waddr, 16'h8080);
      chk("rst_wdata", wdata, 12'h000);
      for (int i = 0; i < 13; i++) begin
         press(v[i].btn);
         draw  = v[i].drw;
         color = v[i].col;
         repeat (v[i].n) tick();
         chk($sformatf("v%0d_x", i), x, v[i].ex);
         chk($sformatf("v%0d_y", i), y, v[i].ey);
         chk($sformatf("v%0d_we", i), we, v[i].ewe);
         chk($sformatf("v%0d_waddr", i), waddr, v[i].ea);
         chk($sformatf("v%0d_wdata", i), wdata, v[i].ed);
      end
      // press latency: single short down press from (80,81)
      press(4'b0100);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("press_x_t%0d", k), x, k >= 8 ? 8'h81 : 8'h80);
         if (k == 8) chk("press_waddr_old", waddr, 16'h8081);
         if (k == 9) chk("press_waddr_new", waddr, 16'h8181);
      end
      press(4'b0000);
      repeat (30) tick();
      chk("press_one_step_x", x, 8'h81);
      chk("press_one_step_y", y, 8'h81);
      // bounce on up, toggling every 2 cycles
      for (int k = 0; k < 40; k++) begin
         btn_up = ((k / 2) % 2) == 0;
         tick();
         chk($sformatf("bounce_x_t%0d", k), x, 8'h81);
         chk($sformatf("bounce_y_t%0d", k), y, 8'h81);
      end
      btn_up = 1'b0;
      repeat (10) tick();
      chk("bounce_end_x", x, 8'h81);
      // reset while auto-repeating, then fresh debounce of the still-held button
      do_reset();
      press(4'b0100);
      repeat (40) tick();
      e = 8'h80 + 8'(nsteps(40));
      chk("midhold_x", x, e);
      rst = 1'b0;
      repeat (2) tick();
      chk("midhold_rst_x", x, 8'h80);
      chk("midhold_rst_we", we, 1'b0);
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("midhold_fresh_x_t%0d", k), x, k >= 8 ? 8'h81 : 8'h80);
      end
      press(4'b0000);
      repeat (12) tick();
      // auto-repeat on left, long enough to wrap through 0x00 to 0xFF
      do_reset();
      press(4'b0010);
      for (int k = 1; k <= 700; k++) begin
         tick();
         e = 8'h80 - 8'(nsteps(k));
         chk($sformatf("rep_y_t%0d", k), y, e);
         if (k == 662) chk("wrap_y_zero", y, 8'h00);
         if (k == 663) chk("wrap_y_ff", y, 8'hFF);
      end
      chk("rep_x", x, 8'h80);
      press(4'b0000);
      repeat (12) tick();
      // painting: we every cycle, waddr trails the cursor by one cycle
      do_reset();
      draw  = 1'b1;
      color = 12'hF00;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("paint_we_on_t%0d", k), we, k >= 3);
      end
      press(4'b0001);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("paint_we_t%0d", k), we, 1'b1);
         chk($sformatf("paint_wdata_t%0d", k), wdata, 12'hF00);
         chk($sformatf("paint_y_t%0d", k), y, k >= 8 ? 8'h81 : 8'h80);
         chk($sformatf("paint_waddr_t%0d", k), waddr, k >= 9 ? 16'h8081 : 16'h8080);
      end
      press(4'b0000);
      draw = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("paint_we_off_t%0d", k), we, k < 3);
      end
      repeat (10) tick();
      chk("paint_end_y", y, 8'h81);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
